// File: rtl/up_counter_ctrl.sv
// Sequencing controller for a WIDTH-bit up-counter: start/stop/pause FSM with a
// programmable terminal value, prescaled advance and one-shot or periodic operation.
module up_counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PS_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                mode,
  input  logic [WIDTH-1:0]    term_val,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]    count,
  output logic [1:0]          state,
  output logic                busy,
  output logic                tick,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    term_q, term_d;
  logic [PS_WIDTH-1:0] ps_cnt_q, ps_cnt_d;
  logic [PS_WIDTH-1:0] ps_lat_q, ps_lat_d;
  logic                mode_q, mode_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  logic                advance;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      term_q   <= '0;
      ps_cnt_q <= '0;
      ps_lat_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      term_q   <= term_d;
      ps_cnt_q <= ps_cnt_d;
      ps_lat_q <= ps_lat_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    term_d   = term_q;
    ps_cnt_d = ps_cnt_q;
    ps_lat_d = ps_lat_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    advance  = (ps_cnt_q == ps_lat_q);

    case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d  = IDLE;
          count_d  = '0;
          ps_cnt_d = '0;
        end else if (start) begin
          state_d  = RUN;
          count_d  = '0;
          ps_cnt_d = '0;
          term_d   = term_val;
          ps_lat_d = prescale;
          mode_d   = mode;
        end
      end
      RUN: begin
        if (stop) begin
          state_d  = IDLE;
          count_d  = '0;
          ps_cnt_d = '0;
        end else if (pause) begin
          state_d = HOLD;
        end else if (advance) begin
          ps_cnt_d = '0;
          // Terminal event: periodic wraps to zero, one-shot parks on term.
          if (count_q == term_q) begin
            tick_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          ps_cnt_d = ps_cnt_q + PS_WIDTH'(1);
        end
      end
      HOLD: begin
        if (stop) begin
          state_d  = IDLE;
          count_d  = '0;
          ps_cnt_d = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == HOLD);
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Scoreboard bench for up_counter_ctrl: a driver pushes expected post-edge outputs
// from a behavioural model, a monitor pops and compares them after every edge.
module tb_up_counter_ctrl;

  localparam int WIDTH    = 4;
  localparam int PS_WIDTH = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;

  logic                clk = 1'b0;
  logic                rst, start, stop, pause, mode;
  logic [WIDTH-1:0]    term_val;
  logic [PS_WIDTH-1:0] prescale;
  logic [WIDTH-1:0]    count;
  logic [1:0]          state;
  logic                busy, tick, done;

  always #5 clk = ~clk;

  up_counter_ctrl #(.WIDTH(WIDTH), .PS_WIDTH(PS_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .mode(mode),
    .term_val(term_val), .prescale(prescale), .count(count), .state(state),
    .busy(busy), .tick(tick), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e, mon_a;

  // Reference model: abstract run phase, cycles elapsed in the current prescale window.
  int m_state = S_IDLE, m_count = 0, m_elapsed = 0;
  int m_term = 0, m_divide = 1, m_periodic = 0, m_tick = 0, m_done = 0;

  function automatic logic [8:0] pack_model();
    logic [3:0] c;
    logic [1:0] s;
    c = 4'(m_count);
    s = 2'(m_state);
    return {c, s, (m_state == S_RUN || m_state == S_HOLD) ? 1'b1 : 1'b0,
            m_tick != 0 ? 1'b1 : 1'b0, m_done != 0 ? 1'b1 : 1'b0};
  endfunction

  task automatic model_step();
    m_tick = 0;
    m_done = 0;
    if (!rst) begin
      m_state = S_IDLE; m_count = 0; m_elapsed = 0;
      m_term = 0; m_divide = 1; m_periodic = 0;
    end else if (stop && m_state != S_IDLE) begin
      m_state = S_IDLE; m_count = 0; m_elapsed = 0;
    end else if (stop) begin
      m_count = 0;
    end else if (m_state == S_IDLE || m_state == S_DONE) begin
      if (start) begin
        m_state = S_RUN; m_count = 0; m_elapsed = 0;
        m_term = int'(term_val); m_divide = int'(prescale) + 1; m_periodic = int'(mode);
      end
    end else if (m_state == S_HOLD) begin
      if (!pause) m_state = S_RUN;
    end else if (pause) begin
      m_state = S_HOLD;
    end else begin
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == m_divide) begin
        m_elapsed = 0;
        if (m_count < m_term) m_count = m_count + 1;
        else begin
          m_tick = 1;
          if (m_periodic != 0) m_count = 0;
          else begin m_done = 1; m_state = S_DONE; end
        end
      end
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic sp, input logic p,
                       input logic md, input int tv, input int ps);
    rst = r; start = s; stop = sp; pause = p; mode = md;
    term_val = 4'(tv); prescale = 4'(ps);
    model_step();
    exp_q.push_back(pack_model());
  endtask

  task automatic cyc(input logic r, input logic s, input logic sp, input logic p,
                     input logic md, input int tv, input int ps);
    @(negedge clk);
    apply(r, s, sp, p, md, tv, ps);
  endtask

  // Idle stimulus carries random config to show it is only captured on start.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {count, state, busy, tick, done};
      if (tick) ticks_seen++;
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got count=%0d state=%b busy=%b tick=%b done=%b, want count=%0d state=%b busy=%b tick=%b done=%b",
                 $time, mon_a[8:5], mon_a[4:3], mon_a[2], mon_a[1], mon_a[0],
                 mon_e[8:5], mon_e[4:3], mon_e[2], mon_e[1], mon_e[0]);
      end
    end
  end

  initial begin
    int base;
    int guard;
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
    term_val = '0; prescale = '0;

    // Reset state, including start asserted while in reset.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7, 0);
    run_cycles(2);

    // Periodic, term=15, prescale=0: three full wraps.
    base = ticks_seen;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 15, 0);
    run_cycles(48);
    settle();
    checks++;
    if (ticks_seen - base != 3) begin
      errors++;
      $display("FAIL periodic_tick_count: got %0d ticks, want 3", ticks_seen - base);
    end

    // Asynchronous reset while running with count=9.
    guard = 0;
    while (m_count != 9 && guard < 40) begin
      run_cycles(1);
      guard++;
    end
    settle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({count, state, busy, tick, done} !== 9'b0 || guard >= 40) begin
      errors++;
      $display("FAIL async_reset: got count=%0d state=%b busy=%b, want count=0 state=00 busy=0",
               count, state, busy);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_cycles(3);

    // One-shot term=5 prescale=2, then restart from DONE.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 2);
    run_cycles(22);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 2);
    run_cycles(6);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Pause at count=7 mid prescale window, release, then stop inside HOLD.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 15, 2);
    guard = 0;
    while (!(m_count == 7 && m_elapsed == 1) && guard < 60) begin
      run_cycles(1);
      guard++;
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3);
    run_cycles(5);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 3);
    run_cycles(3);

    // start&stop together in IDLE; start during RUN must not relatch.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9, 0);
    run_cycles(2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10, 0);
    run_cycles(3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    run_cycles(12);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // term=0 periodic prescale=3: tick every fourth cycle.
    base = ticks_seen;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3);
    run_cycles(16);
    settle();
    checks++;
    if (ticks_seen - base != 4) begin
      errors++;
      $display("FAIL term0_tick_count: got %0d ticks, want 4", ticks_seen - base);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
          1'($urandom),
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
